al_accel_quant_seq: RTL

//  Requester side of the al_accel_quant handshake. Takes raw int32 accumulators from the conv/FC datapath,

---
 rtl/al_accel_quant_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/al_accel_quant_seq.sv
// Requester sequencer for the al_accel_quant block: biases accumulators, issues one quantize
// request per element, applies zero-point and int8 clamp, and packs LANES results per word.
module al_accel_quant_seq #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cfg_count_i,
    input  logic [31:0]      cfg_bias_i,
    input  logic [31:0]      cfg_muler_i,
    input  logic [7:0]       cfg_rshift_i,
    input  logic [31:0]      cfg_offset_i,
    input  logic [7:0]       cfg_act_min_i,
    input  logic [7:0]       cfg_act_max_i,
    input  logic             acc_valid_i,
    input  logic [31:0]      acc_data_i,
    output logic             acc_ready_o,
    output logic             quant_enb_o,
    output logic [31:0]      quant_di_o,
    output logic [31:0]      quant_muler_o,
    output logic [7:0]       quant_rshift_o,
    input  logic [31:0]      quant_do_i,
    input  logic             quant_rdy_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StReq,
        StGap,
        StEmit,
        StDone
    } state_e;

    localparam logic [31:0] TimeoutM1 = 32'(TIMEOUT - 1);
    localparam logic [2:0]  LaneMax   = 3'(LANES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] elem_q;
    logic [31:0]      bias_q;
    logic [31:0]      offset_q;
    logic [7:0]       act_min_q;
    logic [7:0]       act_max_q;
    logic [2:0]       lane_q;
    logic [31:0]      word_q;
    logic [31:0]      qdo_q;
    logic [31:0]      timer_q;

    logic signed [32:0] sum_s;
    logic signed [32:0] lo_s;
    logic signed [32:0] hi_s;
    logic [7:0]         lane_val;
    logic [31:0]        word_nxt;
    logic [CNT_W-1:0]   elem_nxt;
    logic               lane_full;
    logic               is_last;

    // Zero-point add is done at 33 bits so the clamp sees the true sum without wrap.
    always_comb begin
        sum_s = $signed({qdo_q[31], qdo_q}) + $signed({offset_q[31], offset_q});
        lo_s  = $signed({{25{act_min_q[7]}}, act_min_q});
        hi_s  = $signed({{25{act_max_q[7]}}, act_max_q});
        if (lo_s > hi_s) begin
            lane_val = act_max_q;
        end else if (sum_s < lo_s) begin
            lane_val = act_min_q;
        end else if (sum_s > hi_s) begin
            lane_val = act_max_q;
        end else begin
            lane_val = sum_s[7:0];
        end
        word_nxt                 = word_q;
        word_nxt[8*lane_q +: 8]  = lane_val;
        elem_nxt                 = elem_q + 1'b1;
        lane_full                = (lane_q == LaneMax);
        is_last                  = (elem_nxt == count_q);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q        <= StIdle;
            count_q        <= '0;
            elem_q         <= '0;
            bias_q         <= '0;
            offset_q       <= '0;
            act_min_q      <= '0;
            act_max_q      <= '0;
            lane_q         <= '0;
            word_q         <= '0;
            qdo_q          <= '0;
            timer_q        <= '0;
            acc_ready_o    <= 1'b0;
            quant_enb_o    <= 1'b0;
            quant_di_o     <= '0;
            quant_muler_o  <= '0;
            quant_rshift_o <= '0;
            out_valid_o    <= 1'b0;
            out_data_o     <= '0;
            out_last_o     <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        count_q        <= cfg_count_i;
                        bias_q         <= cfg_bias_i;
                        offset_q       <= cfg_offset_i;
                        act_min_q      <= cfg_act_min_i;
                        act_max_q      <= cfg_act_max_i;
                        quant_muler_o  <= cfg_muler_i;
                        quant_rshift_o <= cfg_rshift_i;
                        elem_q         <= '0;
                        lane_q         <= '0;
                        word_q         <= '0;
                        busy_o         <= 1'b1;
                        if (cfg_count_i == '0) begin
                            state_q <= StDone;
                            done_o  <= 1'b1;
                        end else begin
                            state_q     <= StFetch;
                            acc_ready_o <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (acc_valid_i && acc_ready_o) begin
                        acc_ready_o <= 1'b0;
                        quant_di_o  <= acc_data_i + bias_q;
                        quant_enb_o <= 1'b1;
                        timer_q     <= '0;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (quant_rdy_i) begin
                        qdo_q       <= quant_do_i;
                        quant_enb_o <= 1'b0;
                        state_q     <= StGap;
                    end else if ((TIMEOUT != 0) && (timer_q == TimeoutM1)) begin
                        quant_enb_o <= 1'b0;
                        err_o       <= 1'b1;
                        done_o      <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StGap: begin
                    word_q <= word_nxt;
                    elem_q <= elem_nxt;
                    if (lane_full || is_last) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= word_nxt;
                        out_last_o  <= is_last;
                        state_q     <= StEmit;
                    end else begin
                        lane_q      <= lane_q + 1'b1;
                        acc_ready_o <= 1'b1;
                        state_q     <= StFetch;
                    end
                end
                StEmit: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        out_last_o  <= 1'b0;
                        lane_q      <= '0;
                        word_q      <= '0;
                        if (out_last_o) begin
                            done_o  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            acc_ready_o <= 1'b1;
                            state_q     <= StFetch;
                        end
                    end
                end
                StDone: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
